// File: rtl/s3_chien_forney.sv
// RS t=2 decoder stage 3: serial Chien search with Forney magnitude evaluation.
// Emits one error magnitude per position (N-1 down to 0), then a done pulse.
module s3_chien_forney #(
    parameter int N   = 255,
    parameter int FCR = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kes_done,
    input  logic [7:0] rs_lambda0,
    input  logic [7:0] rs_lambda1,
    input  logic [7:0] rs_lambda2,
    input  logic [7:0] rs_omega0,
    input  logic [7:0] rs_omega1,
    output logic       sym_vld,
    output logic [7:0] sym_pos,
    output logic [7:0] sym_err,
    output logic       csf_done,
    output logic [1:0] err_cnt,
    output logic       dec_fail,
    output logic       overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEARCH,
        S_DONE
    } state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1D : 8'h00);
        end
        return acc;
    endfunction

    function automatic logic [7:0] gf_pow(input logic [7:0] e);
        logic [7:0] r;
        logic [7:0] b;
        r = 8'h01;
        b = 8'h02;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, b);
            b = gf_mul(b, b);
        end
        return r;
    endfunction

    // x^254 == 1/x for x != 0, and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    localparam logic [7:0] K1   = gf_pow(8'((255 - (N - 1)) % 255));
    localparam logic [7:0] K2   = gf_pow(8'((510 - 2 * (N - 1)) % 255));
    localparam logic [7:0] X0   = gf_pow(8'(N - 1));
    localparam logic [7:0] A1   = 8'h02;
    localparam logic [7:0] A2   = 8'h04;
    localparam logic [7:0] AINV = gf_pow(8'd254);

    state_t     state_q, state_d;
    logic [7:0] l0_q, l0_d;
    logic [7:0] c1_q, c1_d;
    logic [7:0] c2_q, c2_d;
    logic [7:0] w0_q, w0_d;
    logic [7:0] w1_q, w1_d;
    logic [7:0] x_q, x_d;
    logic [7:0] inv_q, inv_d;
    logic [1:0] deg_q, deg_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] roots_q, roots_d;
    logic       sym_vld_q, sym_vld_d;
    logic [7:0] sym_pos_q, sym_pos_d;
    logic [7:0] sym_err_q, sym_err_d;
    logic       csf_done_q, csf_done_d;
    logic [1:0] err_cnt_q, err_cnt_d;
    logic       dec_fail_q, dec_fail_d;

    logic       root;
    logic       lam_zero;
    logic [7:0] lam_eval;
    logic [7:0] om_eval;
    logic [7:0] e_raw;
    logic [7:0] e_val;

    always_comb begin
        lam_eval = l0_q ^ c1_q ^ c2_q;
        root     = (lam_eval == 8'h00);
        lam_zero = (l0_q == 8'h00) && (c1_q == 8'h00) && (c2_q == 8'h00);
        om_eval  = w0_q ^ w1_q;
        e_raw    = gf_mul(om_eval, inv_q);
        if (FCR == 0) e_val = gf_mul(e_raw, x_q);
        else          e_val = e_raw;
    end

    always_comb begin
        state_d    = state_q;
        l0_d       = l0_q;
        c1_d       = c1_q;
        c2_d       = c2_q;
        w0_d       = w0_q;
        w1_d       = w1_q;
        x_d        = x_q;
        inv_d      = inv_q;
        deg_d      = deg_q;
        cnt_d      = cnt_q;
        roots_d    = roots_q;
        sym_vld_d  = 1'b0;
        sym_pos_d  = 8'h00;
        sym_err_d  = 8'h00;
        csf_done_d = 1'b0;
        err_cnt_d  = err_cnt_q;
        dec_fail_d = dec_fail_q;
        unique case (state_q)
            S_IDLE: begin
                if (kes_done) begin
                    l0_d    = rs_lambda0;
                    c1_d    = rs_lambda1;
                    c2_d    = rs_lambda2;
                    w0_d    = rs_omega0;
                    w1_d    = rs_omega1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // c1/c2 still hold raw l1/l2 here; scale to position N-1
                c1_d       = gf_mul(c1_q, K1);
                c2_d       = gf_mul(c2_q, K2);
                w1_d       = gf_mul(w1_q, K1);
                x_d        = X0;
                inv_d      = gf_inv(c1_q);
                deg_d      = (c2_q != 8'h00) ? 2'd2 :
                             (c1_q != 8'h00) ? 2'd1 : 2'd0;
                cnt_d      = 8'(N - 1);
                roots_d    = 2'd0;
                err_cnt_d  = 2'd0;
                dec_fail_d = 1'b0;
                state_d    = S_SEARCH;
            end
            S_SEARCH: begin
                sym_vld_d = 1'b1;
                sym_pos_d = cnt_q;
                sym_err_d = root ? e_val : 8'h00;
                c1_d      = gf_mul(c1_q, A1);
                c2_d      = gf_mul(c2_q, A2);
                w1_d      = gf_mul(w1_q, A1);
                x_d       = gf_mul(x_q, AINV);
                cnt_d     = cnt_q - 8'd1;
                if (root && roots_q != 2'd3) roots_d = roots_q + 2'd1;
                if (cnt_q == 8'h00) state_d = S_DONE;
            end
            S_DONE: begin
                csf_done_d = 1'b1;
                err_cnt_d  = roots_q;
                // c1 is a nonzero multiple of l1, so c1==0 exactly when l1==0
                dec_fail_d = (roots_q != deg_q) || lam_zero ||
                             ((roots_q != 2'd0) && (c1_q == 8'h00));
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            l0_q       <= '0;
            c1_q       <= '0;
            c2_q       <= '0;
            w0_q       <= '0;
            w1_q       <= '0;
            x_q        <= '0;
            inv_q      <= '0;
            deg_q      <= '0;
            cnt_q      <= '0;
            roots_q    <= '0;
            sym_vld_q  <= 1'b0;
            sym_pos_q  <= '0;
            sym_err_q  <= '0;
            csf_done_q <= 1'b0;
            err_cnt_q  <= '0;
            dec_fail_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            l0_q       <= l0_d;
            c1_q       <= c1_d;
            c2_q       <= c2_d;
            w0_q       <= w0_d;
            w1_q       <= w1_d;
            x_q        <= x_d;
            inv_q      <= inv_d;
            deg_q      <= deg_d;
            cnt_q      <= cnt_d;
            roots_q    <= roots_d;
            sym_vld_q  <= sym_vld_d;
            sym_pos_q  <= sym_pos_d;
            sym_err_q  <= sym_err_d;
            csf_done_q <= csf_done_d;
            err_cnt_q  <= err_cnt_d;
            dec_fail_q <= dec_fail_d;
        end
    end

    assign sym_vld  = sym_vld_q;
    assign sym_pos  = sym_pos_q;
    assign sym_err  = sym_err_q;
    assign csf_done = csf_done_q;
    assign err_cnt  = err_cnt_q;
    assign dec_fail = dec_fail_q;
    assign overrun  = kes_done && (state_q != S_IDLE) && !rst;

endmodule

// File: tb/tb_s3_chien_forney.sv
// Scoreboard bench for s3_chien_forney: N=255/FCR=0, N=255/FCR=1, N=15/FCR=0.
// Expected streams are pushed at stimulus time and popped by a negedge monitor.
module tb_s3_chien_forney;

    typedef struct packed {
        logic        kind;
        logic [31:0] cyc;
        logic [7:0]  pos;
        logic [7:0]  val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mon_off = 1'b0;
    logic [7:0] lam0 = '0, lam1 = '0, lam2 = '0, om0 = '0, om1 = '0;
    logic       kes [3];
    logic       sv [3];
    logic [7:0] sp [3];
    logic [7:0] se [3];
    logic       sd [3];
    logic [1:0] ec [3];
    logic       df [3];
    logic       ov [3];
    int         cyc = 0;
    int         nchk = 0;
    int         nerr = 0;
    exp_t       q0 [$];
    exp_t       q1 [$];
    exp_t       q2 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    s3_chien_forney #(.N(255), .FCR(0)) u_dut0 (
        .clk(clk), .rst(rst), .kes_done(kes[0]),
        .rs_lambda0(lam0), .rs_lambda1(lam1), .rs_lambda2(lam2),
        .rs_omega0(om0), .rs_omega1(om1),
        .sym_vld(sv[0]), .sym_pos(sp[0]), .sym_err(se[0]),
        .csf_done(sd[0]), .err_cnt(ec[0]), .dec_fail(df[0]), .overrun(ov[0]));

    s3_chien_forney #(.N(255), .FCR(1)) u_dut1 (
        .clk(clk), .rst(rst), .kes_done(kes[1]),
        .rs_lambda0(lam0), .rs_lambda1(lam1), .rs_lambda2(lam2),
        .rs_omega0(om0), .rs_omega1(om1),
        .sym_vld(sv[1]), .sym_pos(sp[1]), .sym_err(se[1]),
        .csf_done(sd[1]), .err_cnt(ec[1]), .dec_fail(df[1]), .overrun(ov[1]));

    s3_chien_forney #(.N(15), .FCR(0)) u_dut2 (
        .clk(clk), .rst(rst), .kes_done(kes[2]),
        .rs_lambda0(lam0), .rs_lambda1(lam1), .rs_lambda2(lam2),
        .rs_omega0(om0), .rs_omega1(om1),
        .sym_vld(sv[2]), .sym_pos(sp[2]), .sym_err(se[2]),
        .csf_done(sd[2]), .err_cnt(ec[2]), .dec_fail(df[2]), .overrun(ov[2]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int i, input exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic qclear(input int i);
        case (i)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
        endcase
    endtask

    // One word: n symbols at cycles k0+3.., then the done pulse at k0+n+3
    task automatic push_word(input int i, input int k0, input int n,
                             input int pa, input logic [7:0] ea,
                             input int pb, input logic [7:0] eb,
                             input logic [1:0] cnt, input logic fail);
        exp_t e;
        for (int j = 0; j < n; j++) begin
            int p;
            p      = n - 1 - j;
            e.kind = 1'b0;
            e.cyc  = 32'(k0 + 3 + j);
            e.pos  = 8'(p);
            e.val  = (p == pa) ? ea : (p == pb) ? eb : 8'h00;
            push(i, e);
        end
        e.kind = 1'b1;
        e.cyc  = 32'(k0 + n + 3);
        e.pos  = 8'h00;
        e.val  = {5'b0, fail, cnt};
        push(i, e);
    endtask

    // Called at posedge+2; kes_done is sampled at the next edge (k0)
    task automatic start(input int i, input logic [7:0] l0, input logic [7:0] l1,
                         input logic [7:0] l2, input logic [7:0] w0,
                         input logic [7:0] w1, input logic exp_ovr, output int k0);
        lam0   = l0;
        lam1   = l1;
        lam2   = l2;
        om0    = w0;
        om1    = w1;
        kes[i] = 1'b1;
        k0     = cyc + 1;
        #1;
        chk($sformatf("overrun_dut%0d", i), 64'(ov[i]), 64'(exp_ovr));
        @(posedge clk);
        #2;
        kes[i] = 1'b0;
    endtask

    task automatic wait_to(input int target);
        while (cyc + 1 < target) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drain(input int i, input int max);
        int c;
        c = 0;
        while (qsize(i) != 0 && c < max) begin
            @(posedge clk);
            #2;
            c++;
        end
        nchk++;
        if (qsize(i) != 0) begin
            nerr++;
            $display("FAIL drain_dut%0d: %0d entries left, required 0", i, qsize(i));
            qclear(i);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && !mon_off) begin
            for (int i = 0; i < 3; i++) begin
                exp_t a;
                exp_t e;
                logic have;
                if (sv[i] || sd[i]) begin
                    a.kind = sd[i];
                    a.cyc  = 32'(cyc + 1);
                    a.pos  = sv[i] ? sp[i] : 8'h00;
                    a.val  = sd[i] ? {5'b0, df[i], ec[i]} : se[i];
                    have   = 1'b0;
                    e      = '0;
                    case (i)
                        0: if (q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
                        1: if (q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
                        default: if (q2.size() != 0) begin e = q2.pop_front(); have = 1'b1; end
                    endcase
                    if (!have) begin
                        nchk++;
                        nerr++;
                        $display("FAIL unexpected_dut%0d: got %h expected none", i, a);
                    end else begin
                        chk($sformatf("stream_dut%0d", i), {15'd0, a}, {15'd0, e});
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int kx;
        logic bad;
        for (int i = 0; i < 3; i++) kes[i] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset_dut%0d", i),
                64'({sv[i], sp[i], se[i], sd[i], ec[i], df[i], ov[i]}), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #2;

        // no error
        start(0, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, k);
        push_word(0, k, 255, -1, 8'h00, -1, 8'h00, 2'd0, 1'b0);
        drain(0, 300);

        // single error pos 5 value 10
        start(0, 8'h01, 8'h20, 8'h00, 8'h10, 8'h00, 1'b0, k);
        push_word(0, k, 255, 5, 8'h10, -1, 8'h00, 2'd1, 1'b0);
        drain(0, 300);

        // two errors pos 254 = FF, pos 0 = 01, FCR 0 and FCR 1 overlapping
        start(0, 8'h01, 8'h8F, 8'h8E, 8'hFE, 8'h71, 1'b0, k);
        push_word(0, k, 255, 254, 8'hFF, 0, 8'h01, 2'd2, 1'b0);
        start(1, 8'h01, 8'h8F, 8'h8E, 8'hF0, 8'h7F, 1'b0, k);
        push_word(1, k, 255, 254, 8'hFF, 0, 8'h01, 2'd2, 1'b0);
        drain(0, 300);
        drain(1, 300);

        // N=15, roots at a^-20 and a^-30 fall outside the word
        start(2, 8'h01, 8'hD4, 8'h05, 8'h00, 8'h00, 1'b0, k);
        push_word(2, k, 15, -1, 8'h00, -1, 8'h00, 2'd0, 1'b1);
        drain(2, 40);

        // all-zero Lambda: every position is a root, magnitudes forced to 0
        start(2, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 1'b0, k);
        push_word(2, k, 15, -1, 8'h00, -1, 8'h00, 2'd3, 1'b1);
        drain(2, 40);

        // overrun mid-search, then back-to-back word on the done cycle
        start(0, 8'h01, 8'h20, 8'h00, 8'h10, 8'h00, 1'b0, k);
        push_word(0, k, 255, 5, 8'h10, -1, 8'h00, 2'd1, 1'b0);
        wait_to(k + 100);
        start(0, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 1'b1, kx);
        wait_to(k + 255 + 3);
        start(0, 8'h01, 8'h8F, 8'h8E, 8'hFE, 8'h71, 1'b0, kx);
        push_word(0, kx, 255, 254, 8'hFF, 0, 8'h01, 2'd2, 1'b0);
        drain(0, 600);

        // reset mid-search, then a fresh single-error word
        start(0, 8'h01, 8'h20, 8'h00, 8'h10, 8'h00, 1'b0, k);
        push_word(0, k, 255, 5, 8'h10, -1, 8'h00, 2'd1, 1'b0);
        wait_to(k + 60);
        mon_off = 1'b1;
        rst     = 1'b1;
        qclear(0);
        @(posedge clk);
        #2;
        chk("rst_mid_search",
            64'({sv[0], sp[0], se[0], sd[0], ec[0], df[0]}), 64'd0);
        rst = 1'b0;
        bad = 1'b0;
        repeat (300) begin
            @(posedge clk);
            #2;
            if (sv[0] || sd[0]) bad = 1'b1;
        end
        chk("no_output_after_rst", 64'(bad), 64'd0);
        mon_off = 1'b0;
        start(0, 8'h01, 8'h20, 8'h00, 8'h10, 8'h00, 1'b0, k);
        push_word(0, k, 255, 5, 8'h10, -1, 8'h00, 2'd1, 1'b0);
        drain(0, 300);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
